// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared timing constants and counter sizing for the input conditioner
package input_conditioner_pkg;
    localparam int clk_freq_hz         = 25_000_000;
    localparam int debounce_10ms_cycles = clk_freq_hz / 100;
    localparam int hold_1s_cycles      = clk_freq_hz;

    // Bits needed for a counter that must hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw pins in, conditioned levels/edges/hold flags out
// Ports: async_unsafe_i raw pins; level_o debounced level; rise_o/fall_o edge pulses; hold_o long-press flag
// master drives the pins (board side), slave is the conditioner
interface input_conditioner_if #(parameter int width_p = 4);
    logic [width_p-1:0] async_unsafe_i;
    logic [width_p-1:0] level_o;
    logic [width_p-1:0] rise_o;
    logic [width_p-1:0] fall_o;
    logic [width_p-1:0] hold_o;
    modport master (output async_unsafe_i, input level_o, rise_o, fall_o, hold_o);
    modport slave  (input async_unsafe_i, output level_o, rise_o, fall_o, hold_o);
endinterface

// File: rtl/input_conditioner_channel.sv
// input_conditioner_channel: one channel of synchroniser, debouncer, edge pulses and hold flag
// Ports: clk_i clock; reset_n_i sync active-low reset; pin_i raw pin;
//        level_o debounced level; rise_o/fall_o one-cycle edges; hold_o long-press flag
module input_conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int   sync_stages_p     = 2,
    parameter int   debounce_cycles_p = debounce_10ms_cycles,
    parameter int   hold_cycles_p     = hold_1s_cycles,
    parameter logic invert_p          = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o
);
    localparam int dw = cnt_width(debounce_cycles_p);
    localparam logic [dw-1:0] deb_last = dw'(debounce_cycles_p - 1);

    logic [sync_stages_p-1:0] r_sync;
    logic [dw-1:0]            r_cnt;
    logic                     r_level;
    logic                     r_rise;
    logic                     r_fall;
    logic                     w_s;
    logic                     w_accept;

    // Sync flops reset to the inactive pin level so the inverted view starts at 0.
    assign w_s      = r_sync[sync_stages_p-1] ^ invert_p;
    assign w_accept = (w_s != r_level) && (r_cnt == deb_last);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_sync  <= {sync_stages_p{invert_p}};
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[sync_stages_p-2:0], pin_i};
            // Any cycle agreeing with the current level restarts the count.
            r_cnt   <= (w_s == r_level || w_accept) ? '0 : r_cnt + 1'b1;
            r_level <= w_accept ? w_s : r_level;
            r_rise  <= w_accept && w_s;
            r_fall  <= w_accept && !w_s;
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;

    if (hold_cycles_p > 0) begin : g_hold
        localparam int hw = cnt_width(hold_cycles_p);
        localparam logic [hw-1:0] hold_max = hw'(hold_cycles_p);
        logic [hw-1:0] r_hc;
        logic          r_hold;
        // Counter saturates so a very long press keeps hold_o asserted without wrap.
        always_ff @(posedge clk_i) begin
            if (!reset_n_i || !r_level) begin
                r_hc   <= '0;
                r_hold <= 1'b0;
            end else begin
                r_hc   <= (r_hc == hold_max) ? hold_max : r_hc + 1'b1;
                r_hold <= r_hold || (r_hc == hold_max - 1'b1);
            end
        end
        assign hold_o = r_hold;
    end else begin : g_no_hold
        assign hold_o = 1'b0;
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: width_p independent conditioning channels for raw board inputs
// Ports: clk_i 25 MHz clock; reset_n_i sync active-low reset;
//        bus slave side of input_conditioner_if (pins in, level/rise/fall/hold out)
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int               width_p           = 4,
    parameter int               sync_stages_p     = 2,
    parameter int               debounce_cycles_p = debounce_10ms_cycles,
    parameter int               hold_cycles_p     = hold_1s_cycles,
    parameter logic [width_p-1:0] invert_mask_p   = '0
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input_conditioner_if.slave   bus
);
    logic [width_p-1:0] w_level;
    logic [width_p-1:0] w_rise;
    logic [width_p-1:0] w_fall;
    logic [width_p-1:0] w_hold;

    for (genvar i = 0; i < width_p; i++) begin : g_ch
        input_conditioner_channel #(
            .sync_stages_p    (sync_stages_p),
            .debounce_cycles_p(debounce_cycles_p),
            .hold_cycles_p    (hold_cycles_p),
            .invert_p         (invert_mask_p[i])
        ) u_ch (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .pin_i    (bus.async_unsafe_i[i]),
            .level_o  (w_level[i]),
            .rise_o   (w_rise[i]),
            .fall_o   (w_fall[i]),
            .hold_o   (w_hold[i])
        );
    end

    assign bus.level_o = w_level;
    assign bus.rise_o  = w_rise;
    assign bus.fall_o  = w_fall;
    assign bus.hold_o  = w_hold;
endmodule
